// File: rtl/rand_sampler_pkg.sv
// Shared constants and types for the random-sample reducer and its FIFO.
package rand_sampler_pkg;

    localparam int unsigned DATA_W = 32;

    // A LIMIT of zero leaves the generator output unreduced.
    localparam logic [DATA_W-1:0] RAND_LIMIT_UNBOUNDED = '0;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] limit;
        logic [DATA_W-1:0] mask;
    } range_cfg_t;

endpackage

// File: rtl/rand_fifo.sv
// Synchronous sample FIFO with push, pop, flush and occupancy count.
module rand_fifo
    import rand_sampler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [LVL_W-1:0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full_c;
    logic              empty_c;
    logic              do_pop_c;
    logic              do_push_c;

    // A full FIFO still takes a push when the same edge frees a slot.
    always_comb begin
        full_c    = (level == LVL_W'(DEPTH));
        empty_c   = (level == '0);
        do_pop_c  = pop && !empty_c;
        do_push_c = push && (!full_c || do_pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push_c && !do_pop_c) begin
                level <= level + LVL_W'(1);
            end else if (do_pop_c && !do_push_c) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c && !flush && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/rand_sampler.sv
// Reduces generator words to [0, LIMIT) by mask-and-reject and serves them
// to the CPU through a read-request / valid handshake.
module rand_sampler
    import rand_sampler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rnd_in,
    input  logic              limit_we,
    input  logic [DATA_W-1:0] limit_wdata,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [LVL_W-1:0]  level
);

    range_cfg_t        cfg_q;
    logic [DATA_W-1:0] mask_d;
    logic [DATA_W-1:0] cand_c;
    logic              accept_c;
    rd_state_e         state_q;
    rd_state_e         state_d;
    logic              pop_c;
    logic [DATA_W-1:0] fifo_dout;

    // Smear the leading one of (limit-1) downwards to get the smallest 2^k-1 cover.
    always_comb begin
        mask_d = limit_wdata - DATA_W'(1);
        for (int unsigned sh = 1; sh < DATA_W; sh = sh << 1) begin
            mask_d = mask_d | (mask_d >> sh);
        end
    end

    always_comb begin
        cand_c   = rnd_in & cfg_q.mask;
        accept_c = (cfg_q.limit == RAND_LIMIT_UNBOUNDED) || (cand_c < cfg_q.limit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= '{limit: RAND_LIMIT_UNBOUNDED, mask: '1};
        end else if (limit_we) begin
            cfg_q <= '{limit: limit_wdata, mask: mask_d};
        end
    end

    // A pending request is served the moment anything lands in the FIFO.
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (rd_req) begin
                    if (level != '0) begin
                        pop_c = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (level != '0) begin
                    pop_c   = 1'b1;
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RD_IDLE;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_valid <= pop_c;
            if (pop_c) begin
                rd_data <= fifo_dout;
            end
        end
    end

    assign busy = (state_q == RD_WAIT);

    rand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_c),
        .pop   (pop_c),
        .flush (limit_we),
        .din   (cand_c),
        .dout  (fifo_dout),
        .level (level)
    );

endmodule

// File: tb/tb_rand_sampler.sv
// Randomised bench for rand_sampler with a queue-based reference model and
// a read-data scoreboard.
module tb_rand_sampler;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] rnd_in;
    logic        limit_we;
    logic [31:0] limit_wdata;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    // Reference state: sample queue, pending-read flag, range registers.
    logic [31:0] m_q[$];
    logic [31:0] exp_q[$];
    bit          m_wait;
    logic [31:0] m_lim;
    logic [31:0] m_mask;
    bit          exp_valid;

    rand_sampler #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rnd_in      (rnd_in),
        .limit_we    (limit_we),
        .limit_wdata (limit_wdata),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Smallest 2^k-1 that covers limit-1; LIMIT 0 means all ones.
    function automatic logic [31:0] ref_mask(input logic [31:0] lim);
        longint unsigned target;
        target = (lim == 32'd0) ? 64'hFFFF_FFFF : longint'(lim) - 64'd1;
        for (int k = 0; k <= 32; k++) begin
            if (((64'd1 << k) - 64'd1) >= target) return 32'((64'd1 << k) - 64'd1);
        end
        return 32'hFFFF_FFFF;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        rnd_in = '0;
        limit_we = 1'b0;
        limit_wdata = '0;
        rd_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_wait = 1'b0;
        m_lim = '0;
        m_mask = 32'hFFFF_FFFF;
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
    endtask

    // One clock: drive inputs, advance the model, then compare state outputs.
    task automatic step(input logic [31:0] rnd, input logic we, input logic [31:0] wd, input logic req);
        int          sz;
        bit          pop;
        bit          acc;
        logic [31:0] cand;
        rnd_in = rnd;
        limit_we = we;
        limit_wdata = wd;
        rd_req = req;
        sz = m_q.size();
        pop = 1'b0;
        if (m_wait) begin
            if (sz > 0) begin
                pop = 1'b1;
                m_wait = 1'b0;
            end
        end else if (req) begin
            if (sz > 0) pop = 1'b1;
            else m_wait = 1'b1;
        end
        if (pop) exp_q.push_back(m_q.pop_front());
        cand = rnd & m_mask;
        acc = (m_lim == 32'd0) || (cand < m_lim);
        if (we) begin
            m_q.delete();
            m_lim = wd;
            m_mask = ref_mask(wd);
        end else if (acc && (sz < DEPTH || pop)) begin
            m_q.push_back(cand);
        end
        exp_valid = pop;
        @(posedge clk);
        @(negedge clk);
        limit_we = 1'b0;
        rd_req = 1'b0;
        check("level", 32'(level), 32'(m_q.size()));
        check("busy", 32'(busy), 32'(m_wait));
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read at %0t", rd_data, $time);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] pick_limit();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd2;
            3: return 32'd3;
            4: return 32'd10;
            5: return 32'd100;
            6: return 32'h8000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        rnd_in = '0;
        limit_we = 1'b0;
        limit_wdata = '0;
        rd_req = 1'b0;
        exp_valid = 1'b0;
        do_reset();

        // Unbounded overflow: fifth word is dropped, reads return in order.
        step(32'h11, 1'b0, 32'd0, 1'b0);
        step(32'h22, 1'b0, 32'd0, 1'b0);
        step(32'h33, 1'b0, 32'd0, 1'b0);
        step(32'h44, 1'b0, 32'd0, 1'b0);
        step(32'h55, 1'b0, 32'd0, 1'b0);
        check("ovf_level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) step($urandom, 1'b0, 32'd0, 1'b1);

        // Range 10: 0xC rejected, 3 and 9 accepted, 10 rejected.
        step(32'h0, 1'b1, 32'd10, 1'b0);
        step(32'h1C, 1'b0, 32'd0, 1'b0);
        step(32'h23, 1'b0, 32'd0, 1'b0);
        step(32'hFF9, 1'b0, 32'd0, 1'b0);
        step(32'h0A, 1'b0, 32'd0, 1'b0);
        check("r10_level", 32'(level), 32'd2);
        step(32'hC, 1'b0, 32'd0, 1'b1);
        step(32'hC, 1'b0, 32'd0, 1'b1);
        check("r10_empty", 32'(level), 32'd0);

        // Empty read: request waits until 0x7 arrives.
        step(32'hC, 1'b0, 32'd0, 1'b1);
        step(32'hC, 1'b0, 32'd0, 1'b1);
        step(32'hC, 1'b0, 32'd0, 1'b0);
        step(32'h7, 1'b0, 32'd0, 1'b0);
        check("wait_busy_m1", 32'(busy), 32'd1);
        step(32'hC, 1'b0, 32'd0, 1'b0);
        check("wait_done_data", rd_data, 32'h7);

        // Limit 1: every word reduces to zero.
        step(32'h0, 1'b1, 32'd1, 1'b0);
        for (int i = 0; i < 3; i++) step(32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
        check("lim1_level", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) step(32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);

        // Flush race: full FIFO, limit write + push + read in one cycle.
        step(32'h0, 1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) step($urandom, 1'b0, 32'd0, 1'b0);
        step(32'h1234, 1'b1, 32'd100, 1'b1);
        check("race_level", 32'(level), 32'd0);
        step(32'hFFFF_FF05, 1'b0, 32'd0, 1'b0);
        step(32'hFFFF_FF05, 1'b0, 32'd0, 1'b1);
        check("race_new_range", rd_data, 32'h5);

        // Reset while a read is pending under LIMIT 10.
        step(32'h0, 1'b1, 32'd10, 1'b0);
        step(32'hC, 1'b0, 32'd0, 1'b1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        step(32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
        check("post_rst_unbounded", 32'(level), 32'd1);

        // Randomised traffic with occasional limit writes and resets.
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) do_reset();
            else if (r < 8) step($urandom, 1'b1, pick_limit(), ($urandom_range(0, 2) == 0));
            else step($urandom, 1'b0, 32'd0, ($urandom_range(0, 2) == 0));
        end

        step(32'h0, 1'b1, 32'd1, 1'b0);
        step(32'h0, 1'b0, 32'd0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
